// File: rtl/id_ex_pipeline_reg.sv
// ID/EX pipeline register for the LEGv8 pipeline. It also detects load-use hazards and inserts bubbles into EX.
// Optional: define ID_EX_HAZARD_COUNT_EN to add the saturating bubble_count output.
module id_ex_pipeline_reg #(
   parameter int DATA_W  = 64,
   parameter int REG_AW  = 5,
   parameter int XZR_IDX = 31
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              id_ALUSrc,
   input  logic              id_MemtoReg,
   input  logic              id_RegWrite,
   input  logic              id_MemRead,
   input  logic              id_MemWrite,
   input  logic              id_Branch,
   input  logic              id_UncBranch,
   input  logic [1:0]        id_AluOp,
   input  logic [10:0]       id_opcode,
   input  logic [DATA_W-1:0] id_pc,
   input  logic [DATA_W-1:0] id_rd1,
   input  logic [DATA_W-1:0] id_rd2,
   input  logic [DATA_W-1:0] id_imm,
   input  logic [REG_AW-1:0] id_rs1,
   input  logic [REG_AW-1:0] id_rs2,
   input  logic              id_rs1_used,
   input  logic              id_rs2_used,
   input  logic [REG_AW-1:0] id_rd,
   input  logic              stall_i,
   input  logic              flush_i,
   output logic              ex_ALUSrc,
   output logic              ex_MemtoReg,
   output logic              ex_RegWrite,
   output logic              ex_MemRead,
   output logic              ex_MemWrite,
   output logic              ex_Branch,
   output logic              ex_UncBranch,
   output logic [1:0]        ex_AluOp,
   output logic [10:0]       ex_opcode,
   output logic [DATA_W-1:0] ex_pc,
   output logic [DATA_W-1:0] ex_rd1,
   output logic [DATA_W-1:0] ex_rd2,
   output logic [DATA_W-1:0] ex_imm,
   output logic [REG_AW-1:0] ex_rs1,
   output logic [REG_AW-1:0] ex_rs2,
   output logic [REG_AW-1:0] ex_rd,
   output logic              ex_valid,
   output logic              hazard_stall_o
`ifdef ID_EX_HAZARD_COUNT_EN
   ,
   output logic [31:0]       bubble_count
`endif
);

   localparam logic [REG_AW-1:0] XZR = REG_AW'(XZR_IDX);

   typedef struct packed {
      logic              valid;
      logic              alusrc;
      logic              memtoreg;
      logic              regwrite;
      logic              memread;
      logic              memwrite;
      logic              branch;
      logic              uncbranch;
      logic [1:0]        aluop;
      logic [10:0]       opcode;
      logic [DATA_W-1:0] pc;
      logic [DATA_W-1:0] rd1;
      logic [DATA_W-1:0] rd2;
      logic [DATA_W-1:0] imm;
      logic [REG_AW-1:0] rs1;
      logic [REG_AW-1:0] rs2;
      logic [REG_AW-1:0] rd;
   } ex_bundle_t;

   ex_bundle_t ex_q, id_d;
   logic       hazard;

   always_comb begin
      id_d = '{valid: 1'b1, alusrc: id_ALUSrc, memtoreg: id_MemtoReg,
               regwrite: id_RegWrite, memread: id_MemRead, memwrite: id_MemWrite,
               branch: id_Branch, uncbranch: id_UncBranch, aluop: id_AluOp,
               opcode: id_opcode, pc: id_pc, rd1: id_rd1, rd2: id_rd2, imm: id_imm,
               rs1: id_rs1, rs2: id_rs2, rd: id_rd};
   end

   // Bubbles carry valid=0, so a load can force at most one bubble.
   always_comb begin
      hazard = ex_q.valid & ex_q.memread & (ex_q.rd != XZR) &
               ((id_rs1_used & (id_rs1 == ex_q.rd)) | (id_rs2_used & (id_rs2 == ex_q.rd)));
   end

   // Flush beats stall, and stall beats hazard. Both flush and hazard load an all-zero bubble.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)          ex_q <= '0;
      else if (flush_i)    ex_q <= '0;
      else if (!stall_i) begin
         if (hazard)       ex_q <= '0;
         else              ex_q <= id_d;
      end
   end

`ifdef ID_EX_HAZARD_COUNT_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         bubble_count <= '0;
      else if (!flush_i && !stall_i && hazard && bubble_count != 32'hFFFF_FFFF)
         bubble_count <= bubble_count + 32'd1;
   end
`endif

   assign hazard_stall_o = hazard;
   assign ex_valid       = ex_q.valid;
   assign ex_ALUSrc      = ex_q.alusrc;
   assign ex_MemtoReg    = ex_q.memtoreg;
   assign ex_RegWrite    = ex_q.regwrite;
   assign ex_MemRead     = ex_q.memread;
   assign ex_MemWrite    = ex_q.memwrite;
   assign ex_Branch      = ex_q.branch;
   assign ex_UncBranch   = ex_q.uncbranch;
   assign ex_AluOp       = ex_q.aluop;
   assign ex_opcode      = ex_q.opcode;
   assign ex_pc          = ex_q.pc;
   assign ex_rd1         = ex_q.rd1;
   assign ex_rd2         = ex_q.rd2;
   assign ex_imm         = ex_q.imm;
   assign ex_rs1         = ex_q.rs1;
   assign ex_rs2         = ex_q.rs2;
   assign ex_rd          = ex_q.rd;

endmodule

// File: tb/tb_id_ex_pipeline_reg.sv
// Randomized self-checking bench for id_ex_pipeline_reg, checked against a record-level model of the EX stage.
module tb_id_ex_pipeline_reg;

   logic clk = 1'b0, rst_n = 1'b0;
   logic id_ALUSrc, id_MemtoReg, id_RegWrite, id_MemRead, id_MemWrite, id_Branch, id_UncBranch;
   logic [1:0] id_AluOp;
   logic [10:0] id_opcode;
   logic [63:0] id_pc, id_rd1, id_rd2, id_imm;
   logic [4:0] id_rs1, id_rs2, id_rd;
   logic id_rs1_used, id_rs2_used, stall_i, flush_i;
   logic ex_ALUSrc, ex_MemtoReg, ex_RegWrite, ex_MemRead, ex_MemWrite, ex_Branch, ex_UncBranch;
   logic [1:0] ex_AluOp;
   logic [10:0] ex_opcode;
   logic [63:0] ex_pc, ex_rd1, ex_rd2, ex_imm;
   logic [4:0] ex_rs1, ex_rs2, ex_rd;
   logic ex_valid, hazard_stall_o;
`ifdef ID_EX_HAZARD_COUNT_EN
   logic [31:0] bubble_count;
   logic [31:0] cnt_m = '0;
`endif

   id_ex_pipeline_reg dut (
      .clk(clk), .rst_n(rst_n),
      .id_ALUSrc(id_ALUSrc), .id_MemtoReg(id_MemtoReg), .id_RegWrite(id_RegWrite),
      .id_MemRead(id_MemRead), .id_MemWrite(id_MemWrite), .id_Branch(id_Branch),
      .id_UncBranch(id_UncBranch), .id_AluOp(id_AluOp), .id_opcode(id_opcode),
      .id_pc(id_pc), .id_rd1(id_rd1), .id_rd2(id_rd2), .id_imm(id_imm),
      .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used),
      .id_rd(id_rd), .stall_i(stall_i), .flush_i(flush_i),
      .ex_ALUSrc(ex_ALUSrc), .ex_MemtoReg(ex_MemtoReg), .ex_RegWrite(ex_RegWrite),
      .ex_MemRead(ex_MemRead), .ex_MemWrite(ex_MemWrite), .ex_Branch(ex_Branch),
      .ex_UncBranch(ex_UncBranch), .ex_AluOp(ex_AluOp), .ex_opcode(ex_opcode),
      .ex_pc(ex_pc), .ex_rd1(ex_rd1), .ex_rd2(ex_rd2), .ex_imm(ex_imm),
      .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_rd(ex_rd), .ex_valid(ex_valid),
      .hazard_stall_o(hazard_stall_o)
`ifdef ID_EX_HAZARD_COUNT_EN
      , .bubble_count(bubble_count)
`endif
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic valid, alusrc, memtoreg, regwrite, memread, memwrite, branch, uncbranch;
      logic [1:0] aluop;
      logic [10:0] opcode;
      logic [63:0] pc, rd1, rd2, imm;
      logic [4:0] rs1, rs2, rd;
   } rec_t;

   rec_t m = '0;   // expected EX contents
   int errors = 0, checks = 0;

   function automatic rec_t id_rec();
      return '{1'b1, id_ALUSrc, id_MemtoReg, id_RegWrite, id_MemRead, id_MemWrite, id_Branch,
               id_UncBranch, id_AluOp, id_opcode, id_pc, id_rd1, id_rd2, id_imm, id_rs1, id_rs2, id_rd};
   endfunction

   function automatic rec_t ex_rec();
      return '{ex_valid, ex_ALUSrc, ex_MemtoReg, ex_RegWrite, ex_MemRead, ex_MemWrite, ex_Branch,
               ex_UncBranch, ex_AluOp, ex_opcode, ex_pc, ex_rd1, ex_rd2, ex_imm, ex_rs1, ex_rs2, ex_rd};
   endfunction

   // A load-use conflict exists when a real load in EX writes a non-zero register that ID reads.
   function automatic logic model_hazard();
      return m.valid && m.memread && m.rd != 5'd31 &&
             ((id_rs1_used && id_rs1 == m.rd) || (id_rs2_used && id_rs2 == m.rd));
   endfunction

   task automatic tick();
      rec_t nxt;
      logic hz;
      hz = model_hazard();
      if (flush_i)      nxt = '0;
      else if (stall_i) nxt = m;
      else if (hz)      nxt = '0;
      else              nxt = id_rec();
`ifdef ID_EX_HAZARD_COUNT_EN
      if (!flush_i && !stall_i && hz && cnt_m != 32'hFFFF_FFFF) cnt_m = cnt_m + 1;
`endif
      @(posedge clk);
      m = nxt;
      #1;
   endtask

   task automatic rand_id();
      {id_ALUSrc, id_MemtoReg, id_RegWrite, id_MemWrite, id_Branch, id_UncBranch} = 6'($urandom);
      id_MemRead = ($urandom_range(0, 1) == 1);
      id_AluOp = 2'($urandom);
      id_opcode = 11'($urandom);
      id_pc = {$urandom, $urandom}; id_rd1 = {$urandom, $urandom};
      id_rd2 = {$urandom, $urandom}; id_imm = {$urandom, $urandom};
      id_rs1 = ($urandom_range(0, 5) == 0) ? 5'd31 : 5'($urandom_range(0, 5));
      id_rs2 = ($urandom_range(0, 5) == 0) ? 5'd31 : 5'($urandom_range(0, 5));
      id_rd  = ($urandom_range(0, 5) == 0) ? 5'd31 : 5'($urandom_range(0, 5));
      id_rs1_used = 1'($urandom); id_rs2_used = 1'($urandom);
   endtask

   task automatic set_ldur(input logic [4:0] rd, input logic [63:0] imm);
      rand_id();
      {id_ALUSrc, id_MemtoReg, id_RegWrite, id_MemRead, id_MemWrite, id_Branch, id_UncBranch} = 7'b1111000;
      id_AluOp = 2'b00; id_opcode = 11'h7C2; id_rd = rd; id_imm = imm;
      id_rs1 = 5'd1; id_rs1_used = 1'b1; id_rs2_used = 1'b0;
   endtask

   task automatic set_add(input logic [4:0] rs1, input logic [4:0] rs2,
                          input logic u1, input logic u2, input logic [4:0] rd);
      rand_id();
      {id_ALUSrc, id_MemtoReg, id_RegWrite, id_MemRead, id_MemWrite, id_Branch, id_UncBranch} = 7'b0010000;
      id_AluOp = 2'b10; id_opcode = 11'h458;
      id_rs1 = rs1; id_rs2 = rs2; id_rs1_used = u1; id_rs2_used = u2; id_rd = rd;
   endtask

   task automatic do_reset();
      rst_n = 1'b0; #3; rst_n = 1'b1;
      m = '0;
`ifdef ID_EX_HAZARD_COUNT_EN
      cnt_m = '0;
`endif
   endtask

   task automatic test_reset();
      stall_i = 0; flush_i = 0;
      set_ldur(5'd3, 64'h10);
      #2;
      checks++; if (ex_rec() !== rec_t'(0)) begin errors++; $display("FAIL reset_initial: got %h want 0", ex_rec()); end
      @(negedge clk); rst_n = 1'b1;
      tick();
      set_add(5'd3, 5'd0, 1'b1, 1'b0, 5'd4); stall_i = 1'b1; #1;
      checks++; if (hazard_stall_o !== 1'b1) begin errors++; $display("FAIL reset_prehazard: got %b want 1", hazard_stall_o); end
      rst_n = 1'b0; #1; m = '0;
      checks++; if (ex_rec() !== rec_t'(0)) begin errors++; $display("FAIL reset_async: got %h want 0", ex_rec()); end
      checks++; if (hazard_stall_o !== 1'b0) begin errors++; $display("FAIL reset_hazard: got %b want 0", hazard_stall_o); end
      @(negedge clk); rst_n = 1'b1; stall_i = 1'b0;
`ifdef ID_EX_HAZARD_COUNT_EN
      cnt_m = '0;
`endif
   endtask

   task automatic test_capture();
      set_ldur(5'd3, 64'h10);
      tick();
      checks++;
      if (ex_MemRead !== 1'b1 || ex_rd !== 5'd3 || ex_imm !== 64'h10 || ex_valid !== 1'b1 || ex_rec() !== m) begin
         errors++; $display("FAIL capture_ldur: got %h want %h", ex_rec(), m);
      end
   endtask

   task automatic test_load_use();
      set_add(5'd3, 5'd2, 1'b1, 1'b1, 5'd6); #1;
      checks++; if (hazard_stall_o !== 1'b1) begin errors++; $display("FAIL loaduse_detect: got %b want 1", hazard_stall_o); end
      tick();
      checks++;
      if (ex_valid !== 1'b0 || {ex_RegWrite, ex_MemWrite, ex_MemRead, ex_Branch, ex_UncBranch, ex_AluOp} !== 7'b0) begin
         errors++; $display("FAIL loaduse_bubble: got %h want 0", ex_rec());
      end
      checks++; if (hazard_stall_o !== 1'b0) begin errors++; $display("FAIL loaduse_clear: got %b want 0", hazard_stall_o); end
      tick();
      checks++; if (ex_rec() !== m || ex_valid !== 1'b1 || ex_rd !== 5'd6) begin errors++; $display("FAIL loaduse_capture: got %h want %h", ex_rec(), m); end
   endtask

   task automatic test_xzr_unused();
      set_ldur(5'd31, 64'h8); tick();
      set_add(5'd31, 5'd31, 1'b1, 1'b1, 5'd2); #1;
      checks++; if (hazard_stall_o !== 1'b0) begin errors++; $display("FAIL xzr_hazard: got %b want 0", hazard_stall_o); end
      set_ldur(5'd5, 64'h18); tick();
      set_add(5'd1, 5'd5, 1'b1, 1'b0, 5'd2); #1;
      checks++; if (hazard_stall_o !== 1'b0) begin errors++; $display("FAIL unused_rs2: got %b want 0", hazard_stall_o); end
      tick();
      checks++; if (ex_rec() !== m || ex_valid !== 1'b1) begin errors++; $display("FAIL unused_capture: got %h want %h", ex_rec(), m); end
   endtask

   task automatic test_stall_flush();
      rec_t held;
      set_ldur(5'd7, 64'h20); tick();
      held = m;
      stall_i = 1'b1;
      for (int i = 0; i < 3; i++) begin
         rand_id(); tick();
         checks++; if (ex_rec() !== held) begin errors++; $display("FAIL stall_hold%0d: got %h want %h", i, ex_rec(), held); end
      end
      flush_i = 1'b1; tick();
      checks++; if (ex_valid !== 1'b0 || ex_rec() !== rec_t'(0)) begin errors++; $display("FAIL stall_flush: got %h want 0", ex_rec()); end
      flush_i = 1'b0; stall_i = 1'b0;
      set_ldur(5'd4, 64'h30); tick();
      set_add(5'd1, 5'd4, 1'b0, 1'b1, 5'd9); stall_i = 1'b1; tick();
      checks++; if (hazard_stall_o !== 1'b1 || ex_rd !== 5'd4 || ex_MemRead !== 1'b1) begin
         errors++; $display("FAIL stall_hazard_hold: got hz=%b rd=%0d want hz=1 rd=4", hazard_stall_o, ex_rd);
      end
      stall_i = 1'b0; tick();
      checks++; if (ex_valid !== 1'b0 || ex_rec() !== m) begin errors++; $display("FAIL stall_then_bubble: got %h want %h", ex_rec(), m); end
   endtask

   task automatic test_random();
      for (int i = 0; i < 400; i++) begin
         rand_id();
         stall_i = ($urandom_range(0, 7) == 0);
         flush_i = ($urandom_range(0, 9) == 0);
         #1;
         checks++; if (hazard_stall_o !== model_hazard()) begin errors++; $display("FAIL rand_hazard@%0d: got %b want %b", i, hazard_stall_o, model_hazard()); end
         tick();
         checks++; if (ex_rec() !== m) begin errors++; $display("FAIL rand_ex@%0d: got %h want %h", i, ex_rec(), m); end
`ifdef ID_EX_HAZARD_COUNT_EN
         checks++; if (bubble_count !== cnt_m) begin errors++; $display("FAIL rand_count@%0d: got %0d want %0d", i, bubble_count, cnt_m); end
`endif
      end
      stall_i = 1'b0; flush_i = 1'b0;
   endtask

`ifdef ID_EX_HAZARD_COUNT_EN
   task automatic test_bubble_count();
      do_reset();
      for (int i = 0; i < 3; i++) begin
         set_ldur(5'd3, 64'h10); tick();
         set_add(5'd3, 5'd0, 1'b1, 1'b0, 5'd8); tick(); tick();
      end
      set_ldur(5'd3, 64'h10); tick();
      set_add(5'd3, 5'd0, 1'b1, 1'b0, 5'd8); flush_i = 1'b1; tick(); flush_i = 1'b0;
      checks++; if (bubble_count !== 32'd3) begin errors++; $display("FAIL count_three: got %0d want 3", bubble_count); end
      @(negedge clk);
      force dut.bubble_count = 32'hFFFF_FFFF;
      #1; release dut.bubble_count;
      cnt_m = 32'hFFFF_FFFF;
      set_ldur(5'd3, 64'h10); tick();
      set_add(5'd3, 5'd0, 1'b1, 1'b0, 5'd8); tick();
      checks++; if (bubble_count !== 32'hFFFF_FFFF || ex_valid !== 1'b0) begin
         errors++; $display("FAIL count_saturate: got %h want ffffffff", bubble_count);
      end
   endtask
`endif

   initial begin
      test_reset();
      test_capture();
      test_load_use();
      test_xzr_unused();
      test_stall_flush();
      test_random();
`ifdef ID_EX_HAZARD_COUNT_EN
      test_bubble_count();
`endif
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
